// File: rtl/tcm_dport_arbiter_pkg.sv
// rtl/tcm_dport_arbiter_pkg.sv - shared widths, owner/FSM enums and debug access size for the TCM data-port arbiter
package tcm_dport_arbiter_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int SIZE_WIDTH     = 4;
    localparam int REG_DATA_WIDTH = 32;
    localparam int BUS_DATA_WIDTH = 64;

    localparam logic [SIZE_WIDTH-1:0] TCM_DBG_SIZE = SIZE_WIDTH'(4);

    typedef enum logic [1:0] {
        NONE,
        LOAD,
        DBG
    } tcm_arb_owner_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } tcm_dbg_state_t;

endpackage

// File: rtl/tcm_arb_starve_cnt.sv
// rtl/tcm_arb_starve_cnt.sv - saturating debug starvation counter producing the force-grant flag
module tcm_arb_starve_cnt #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic force_dbg
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_dbg = (cnt_q >= LIMIT);

endmodule

// File: rtl/tcm_dport_arbiter.sv
// rtl/tcm_dport_arbiter.sv - arbitrates TCM read/write channels between load unit, store buffer and debug port
module tcm_dport_arbiter
    import tcm_dport_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      load_req,
    output logic                      load_ack,
    input  logic [ADDR_WIDTH-1:0]     load_addr,
    input  logic [SIZE_WIDTH-1:0]     load_size,
    output logic                      load_rvalid,
    output logic [BUS_DATA_WIDTH-1:0] load_rdata,

    input  logic                      stbuf_req,
    output logic                      stbuf_ack,
    input  logic [ADDR_WIDTH-1:0]     stbuf_addr,
    input  logic [SIZE_WIDTH-1:0]     stbuf_size,
    input  logic [REG_DATA_WIDTH-1:0] stbuf_data,
    input  logic                      stbuf_full,

    input  logic                      dbg_req,
    output logic                      dbg_ack,
    input  logic                      dbg_we,
    input  logic [ADDR_WIDTH-1:0]     dbg_addr,
    input  logic [REG_DATA_WIDTH-1:0] dbg_wdata,
    output logic                      dbg_rvalid,
    output logic [REG_DATA_WIDTH-1:0] dbg_rdata,

    output logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_read_addr,
    output logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_read_size,
    output logic                      bus_tcm_stbuf_rd,
    output logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_write_addr,
    output logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_write_size,
    output logic [REG_DATA_WIDTH-1:0] bus_tcm_stbuf_data,
    output logic                      bus_tcm_stbuf_wr,
    input  logic [BUS_DATA_WIDTH-1:0] tcm_bus_stbuf_data
);

    tcm_dbg_state_t state_q, state_d;
    tcm_arb_owner_t tag_q, tag_d;

    logic [ADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
    logic [SIZE_WIDTH-1:0]     rd_size_q, rd_size_d;
    logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
    logic [SIZE_WIDTH-1:0]     wr_size_q, wr_size_d;
    logic [REG_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic force_dbg;
    logic dbg_issue;
    logic dbg_rd_win;
    logic dbg_wr_win;
    logic load_win;
    logic stbuf_win;
    logic starve_inc;

    // Grants are gated by rst so nothing is acknowledged while reset is held.
    always_comb begin
        dbg_issue  = rst && (state_q == ISSUE) && dbg_req;
        dbg_rd_win = dbg_issue && !dbg_we && (!load_req || force_dbg);
        dbg_wr_win = dbg_issue && dbg_we && (!stbuf_req || (force_dbg && !stbuf_full));
        load_win   = rst && load_req && !dbg_rd_win;
        stbuf_win  = rst && stbuf_req && !dbg_wr_win;
        starve_inc = dbg_issue && !dbg_rd_win && !dbg_wr_win;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dbg_req) state_d = ISSUE;
            end
            ISSUE: begin
                if (!dbg_req)        state_d = IDLE;
                else if (dbg_wr_win) state_d = IDLE;
                else if (dbg_rd_win) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tag_d = NONE;
        if (load_win)        tag_d = LOAD;
        else if (dbg_rd_win) tag_d = DBG;
    end

    // Channel outputs show the winner this cycle and otherwise hold the last issued values.
    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_size_d = rd_size_q;
        wr_addr_d = wr_addr_q;
        wr_size_d = wr_size_q;
        wr_data_d = wr_data_q;
        if (load_win) begin
            rd_addr_d = load_addr;
            rd_size_d = load_size;
        end else if (dbg_rd_win) begin
            rd_addr_d = dbg_addr;
            rd_size_d = TCM_DBG_SIZE;
        end
        if (stbuf_win) begin
            wr_addr_d = stbuf_addr;
            wr_size_d = stbuf_size;
            wr_data_d = stbuf_data;
        end else if (dbg_wr_win) begin
            wr_addr_d = dbg_addr;
            wr_size_d = TCM_DBG_SIZE;
            wr_data_d = dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tag_q     <= NONE;
            rd_addr_q <= '0;
            rd_size_q <= '0;
            wr_addr_q <= '0;
            wr_size_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            rd_addr_q <= rd_addr_d;
            rd_size_q <= rd_size_d;
            wr_addr_q <= wr_addr_d;
            wr_size_q <= wr_size_d;
            wr_data_q <= wr_data_d;
        end
    end

    tcm_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_starve_cnt (
        .clk       (clk),
        .rst_n     (rst),
        .inc       (starve_inc),
        .clr       (dbg_ack),
        .force_dbg (force_dbg)
    );

    assign load_ack    = load_win;
    assign stbuf_ack   = stbuf_win;
    assign dbg_ack     = dbg_rd_win || dbg_wr_win;
    assign load_rvalid = (tag_q == LOAD);
    assign load_rdata  = tcm_bus_stbuf_data;
    assign dbg_rvalid  = (state_q == RESP);
    assign dbg_rdata   = tcm_bus_stbuf_data[REG_DATA_WIDTH-1:0];

    assign bus_tcm_stbuf_rd         = load_win || dbg_rd_win;
    assign bus_tcm_stbuf_read_addr  = rd_addr_d;
    assign bus_tcm_stbuf_read_size  = rd_size_d;
    assign bus_tcm_stbuf_wr         = stbuf_win || dbg_wr_win;
    assign bus_tcm_stbuf_write_addr = wr_addr_d;
    assign bus_tcm_stbuf_write_size = wr_size_d;
    assign bus_tcm_stbuf_data       = wr_data_d;

endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// tb/tb_tcm_dport_arbiter.sv - scoreboard testbench for tcm_dport_arbiter with a behavioural TCM
module tb_tcm_dport_arbiter;
    import tcm_dport_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic load_req = 1'b0, load_ack, load_rvalid;
    logic [ADDR_WIDTH-1:0] load_addr = '0;
    logic [SIZE_WIDTH-1:0] load_size = '0;
    logic [BUS_DATA_WIDTH-1:0] load_rdata;
    logic stbuf_req = 1'b0, stbuf_ack, stbuf_full = 1'b0;
    logic [ADDR_WIDTH-1:0] stbuf_addr = '0;
    logic [SIZE_WIDTH-1:0] stbuf_size = '0;
    logic [REG_DATA_WIDTH-1:0] stbuf_data = '0;
    logic dbg_req = 1'b0, dbg_ack, dbg_we = 1'b0, dbg_rvalid;
    logic [ADDR_WIDTH-1:0] dbg_addr = '0;
    logic [REG_DATA_WIDTH-1:0] dbg_wdata = '0, dbg_rdata;
    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic [SIZE_WIDTH-1:0] rd_size, wr_size;
    logic [REG_DATA_WIDTH-1:0] wr_data;
    logic rd, wr;
    logic [BUS_DATA_WIDTH-1:0] tcm_rdata = '0;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t load_q[$];
    exp_t dbg_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    tcm_dport_arbiter #(.STARVE_LIMIT(8), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .load_req(load_req), .load_ack(load_ack), .load_addr(load_addr), .load_size(load_size),
        .load_rvalid(load_rvalid), .load_rdata(load_rdata),
        .stbuf_req(stbuf_req), .stbuf_ack(stbuf_ack), .stbuf_addr(stbuf_addr), .stbuf_size(stbuf_size),
        .stbuf_data(stbuf_data), .stbuf_full(stbuf_full),
        .dbg_req(dbg_req), .dbg_ack(dbg_ack), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .bus_tcm_stbuf_read_addr(rd_addr), .bus_tcm_stbuf_read_size(rd_size), .bus_tcm_stbuf_rd(rd),
        .bus_tcm_stbuf_write_addr(wr_addr), .bus_tcm_stbuf_write_size(wr_size),
        .bus_tcm_stbuf_data(wr_data), .bus_tcm_stbuf_wr(wr),
        .tcm_bus_stbuf_data(tcm_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural TCM: read data one cycle after rd, write-through on same-address collision.
    always @(posedge clk) begin
        if (wr) mem[wr_addr[9:2]] <= wr_data;
        if (rd) tcm_rdata <= {32'h0, (wr && (wr_addr[9:2] == rd_addr[9:2])) ? wr_data : mem[rd_addr[9:2]]};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_load(input logic [31:0] d);
        load_q.push_back('{data: d, due: cyc + 1});
    endtask

    task automatic push_dbg(input logic [31:0] d);
        dbg_q.push_back('{data: d, due: cyc + 1});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        load_req = 1'b0; stbuf_req = 1'b0; dbg_req = 1'b0; stbuf_full = 1'b0; dbg_we = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (load_q.size() > 0 && load_q[0].due == cyc) begin
            e = load_q.pop_front();
            check("load_rvalid", 64'(load_rvalid), 64'd1);
            check("load_rdata", 64'(load_rdata[31:0]), 64'(e.data));
        end else begin
            check("load_rvalid_idle", 64'(load_rvalid), 64'd0);
        end
        if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
            e = dbg_q.pop_front();
            check("dbg_rvalid", 64'(dbg_rvalid), 64'd1);
            check("dbg_rdata", 64'(dbg_rdata), 64'(e.data));
        end else begin
            check("dbg_rvalid_idle", 64'(dbg_rvalid), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA000_0000 | i;
            ref_mem[i] = 32'hA000_0000 | i;
        end

        // Reset held with every requester active
        load_req = 1'b1; stbuf_req = 1'b1; dbg_req = 1'b1;
        load_addr = 32'h44; stbuf_addr = 32'h48; dbg_addr = 32'h4c;
        load_size = 4'd4; stbuf_size = 4'd4; stbuf_data = 32'hdead_beef;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({load_ack, stbuf_ack, dbg_ack, load_rvalid, dbg_rvalid, rd, wr}), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_sizes", 64'({rd_size, wr_size}), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        idle_all();
        @(negedge clk);
        rst = 1'b1;
        step();

        // 1: first load after reset
        load_req = 1'b1; load_addr = 32'h0; load_size = 4'd4;
        @(negedge clk);
        check("t1_load_ack", 64'(load_ack), 64'd1);
        check("t1_rd", 64'(rd), 64'd1);
        check("t1_rd_addr", 64'(rd_addr), 64'h0);
        push_load(ref_mem[0]);
        step();
        load_req = 1'b0;
        @(negedge clk);
        step();

        // 2: concurrent store @0x0 and load @0x4
        stbuf_req = 1'b1; stbuf_addr = 32'h0; stbuf_size = 4'd4; stbuf_data = 32'h1234_5678;
        load_req = 1'b1; load_addr = 32'h4;
        @(negedge clk);
        check("t2_load_ack", 64'(load_ack), 64'd1);
        check("t2_stbuf_ack", 64'(stbuf_ack), 64'd1);
        check("t2_wr", 64'(wr), 64'd1);
        check("t2_wr_addr", 64'(wr_addr), 64'h0);
        check("t2_wr_data", 64'(wr_data), 64'h1234_5678);
        push_load(ref_mem[1]);
        ref_mem[0] = 32'h1234_5678;
        step();
        idle_all();
        step();

        // 3: debug read starved by continuous loads, force-granted on ISSUE cycle 9
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0;
        load_req = 1'b1; load_addr = 32'h20;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t3_dbg_ack", 64'(dbg_ack), 64'(c == 9));
            check("t3_load_ack", 64'(load_ack), 64'(c != 9));
            if (c == 9) begin
                check("t3_rd_addr", 64'(rd_addr), 64'h0);
                check("t3_rd_size", 64'(rd_size), 64'd4);
                push_dbg(ref_mem[0]);
            end else begin
                push_load(ref_mem[8]);
            end
            step();
        end
        idle_all();
        @(negedge clk);
        step();

        // 4: debug write blocked while store buffer is full
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h8; dbg_wdata = 32'ha5a5_a5a5;
        stbuf_req = 1'b1; stbuf_full = 1'b1; stbuf_addr = 32'h40; stbuf_data = 32'h5555_aaaa;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            check("t4_dbg_ack_full", 64'(dbg_ack), 64'd0);
            check("t4_stbuf_ack_full", 64'(stbuf_ack), 64'd1);
            step();
        end
        ref_mem[16] = 32'h5555_aaaa;
        stbuf_full = 1'b0;
        @(negedge clk);
        check("t4_dbg_ack", 64'(dbg_ack), 64'd1);
        check("t4_stbuf_ack", 64'(stbuf_ack), 64'd0);
        check("t4_wr_addr", 64'(wr_addr), 64'h8);
        check("t4_wr_data", 64'(wr_data), 64'ha5a5_a5a5);
        check("t4_wr_size", 64'(wr_size), 64'd4);
        ref_mem[2] = 32'ha5a5_a5a5;
        step();
        idle_all();
        load_req = 1'b1; load_addr = 32'h8;
        @(negedge clk);
        check("t4_rb_ack", 64'(load_ack), 64'd1);
        push_load(ref_mem[2]);
        step();
        load_addr = 32'h40;
        @(negedge clk);
        check("t4_rb2_ack", 64'(load_ack), 64'd1);
        push_load(ref_mem[16]);
        step();
        idle_all();
        step();

        // 5: same-cycle debug write and load read of 0x10
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hcafe_f00d;
        @(negedge clk);
        check("t5_dbg_ack_idle", 64'(dbg_ack), 64'd0);
        step();
        load_req = 1'b1; load_addr = 32'h10;
        @(negedge clk);
        check("t5_dbg_ack", 64'(dbg_ack), 64'd1);
        check("t5_load_ack", 64'(load_ack), 64'd1);
        ref_mem[4] = 32'hcafe_f00d;
        push_load(ref_mem[4]);
        step();
        idle_all();
        step();

        // 6: reset asserted while a debug read is in RESP
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        @(negedge clk);
        step();
        @(negedge clk);
        check("t6_dbg_ack", 64'(dbg_ack), 64'd1);
        step();
        dbg_req = 1'b0;
        check("t6_rvalid_resp", 64'(dbg_rvalid), 64'd1);
        check("t6_rdata_resp", 64'(dbg_rdata), 64'(ref_mem[4]));
        #2;
        rst = 1'b0;
        #1;
        check("t6_rvalid_drop", 64'(dbg_rvalid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        @(negedge clk);
        check("t6b_dbg_ack_idle", 64'(dbg_ack), 64'd0);
        step();
        @(negedge clk);
        check("t6b_dbg_ack", 64'(dbg_ack), 64'd1);
        push_dbg(ref_mem[4]);
        step();
        idle_all();
        repeat (3) step();

        check("load_q_empty", 64'(load_q.size()), 64'd0);
        check("dbg_q_empty", 64'(dbg_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
